// File: rtl/matmul_stream_if_pkg.sv
// Shared definitions for the matmul streaming front/back end.
// Provides the FP16 word type, the default vector length, the
// controller state encoding and a pair of handy FP16 constants.
package vm_pkg;

    typedef logic [15:0] fp16_t;

    localparam int VM_N = 4;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } vm_state_t;

    localparam fp16_t FP16_ONE  = 16'h3C00;
    localparam fp16_t FP16_ZERO = 16'h0000;

endpackage

// File: rtl/matmul_stream_if_out_ser.sv
// Result serialiser for the matmul stream interface.
// On 'load' it captures the parallel result vector and then presents it
// one word at a time on a valid/ready output, flagging the final word
// with out_last. 'done' marks the handshake of that final word.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   load          capture x_i and start a new output group
//   x_i           parallel result from the datapath
//   out_ready     downstream accepts a word
//   out_valid     a result word is on out_data
//   out_data      current result word
//   out_last      high while the N-th word is presented
//   done          final word is being transferred this cycle
module matmul_out_ser #(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [N-1:0][W-1:0] x_i,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [W-1:0]        out_data,
    output logic                out_last,
    output logic                done
);

    localparam int IW = $clog2(N);

    logic [N-1:0][W-1:0] x_cap_r;
    logic [IW-1:0]       out_idx_r;
    logic                valid_r;
    logic                xfer_s;
    logic                last_s;

    // Handshake and last-word decode
    always_comb begin
        last_s = (out_idx_r == IW'(N-1));
        xfer_s = valid_r && out_ready;
    end

    // Capture register, output index and valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cap_r   <= '0;
            out_idx_r <= '0;
            valid_r   <= 1'b0;
        end else if (load) begin
            x_cap_r   <= x_i;
            out_idx_r <= '0;
            valid_r   <= 1'b1;
        end else if (xfer_s) begin
            if (last_s) begin
                // Wrap to 0 so out_last drops together with out_valid.
                out_idx_r <= '0;
                valid_r   <= 1'b0;
            end else begin
                out_idx_r <= out_idx_r + IW'(1);
            end
        end
    end

    assign out_valid = valid_r;
    assign out_data  = x_cap_r[out_idx_r];
    assign out_last  = last_s;
    assign done      = xfer_s && last_s;

endmodule

// File: rtl/matmul_stream_if.sv
// Streaming wrapper around the 4x4 FP16 matmul datapath.
// Serial FP16 words are assembled into the matrix (a_o, row-major) and
// the vertex (b_o). After the final vertex word the inputs are held for
// LATENCY cycles, the datapath result x_i is captured and re-emitted as
// N words on the output stream. Words pass bit-exact.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready/in_data input word stream, in_mat selects matrix
//   a_o, b_o                  parallel operands to the datapath
//   x_i                       parallel result from the datapath
//   out_valid/out_ready/out_data/out_last  result word stream
//   mat_loaded                sticky: a full matrix has been written
//   err                       one-cycle pulse when an input word is dropped
module matmul_stream_if
    import vm_pkg::*;
#(
    parameter int W       = 16,
    parameter int N       = VM_N,
    parameter int LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_data,
    input  logic                  in_mat,
    output logic [N*N-1:0][W-1:0] a_o,
    output logic [N-1:0][W-1:0]   b_o,
    input  logic [N-1:0][W-1:0]   x_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_data,
    output logic                  out_last,
    output logic                  mat_loaded,
    output logic                  err
);

    localparam int MW = $clog2(N*N);
    localparam int VW = $clog2(N);
    localparam int CW = $clog2(LATENCY+1);

    vm_state_t             state_r;
    vm_state_t             state_s;
    logic [MW-1:0]         mat_idx_r;
    logic [VW-1:0]         vec_idx_r;
    logic [CW-1:0]         wait_cnt_r;
    logic [N*N-1:0][W-1:0] a_r;
    logic [N-1:0][W-1:0]   b_r;
    logic                  mat_loaded_r;
    logic                  err_r;

    logic                  in_xfer_s;
    logic                  mat_ok_s;
    logic                  vec_ok_s;
    logic                  drop_s;
    logic                  vec_last_s;
    logic                  cap_s;
    logic                  ser_done_s;

    // Input acceptance decode and capture timing
    always_comb begin
        in_xfer_s  = in_valid && (state_r == S_FILL);
        // Matrix words are only legal between vertices.
        mat_ok_s   = in_xfer_s && in_mat && (vec_idx_r == VW'(0));
        vec_ok_s   = in_xfer_s && !in_mat && mat_loaded_r;
        drop_s     = in_xfer_s && !mat_ok_s && !vec_ok_s;
        vec_last_s = vec_ok_s && (vec_idx_r == VW'(N-1));
        // wait_cnt is 0 on the first S_WAIT cycle, so LATENCY-1 here
        // lands the capture on edge LATENCY after the last b_o write.
        cap_s      = (state_r == S_WAIT) && (wait_cnt_r == CW'(LATENCY-1));
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_FILL: begin
                if (vec_last_s) begin
                    state_s = S_WAIT;
                end else begin
                    state_s = S_FILL;
                end
            end
            S_WAIT: begin
                if (cap_s) begin
                    state_s = S_DRAIN;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (ser_done_s) begin
                    state_s = S_FILL;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            default: state_s = S_FILL;
        endcase
    end

    // State register, operand assembly, counters and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_FILL;
            mat_idx_r    <= '0;
            vec_idx_r    <= '0;
            wait_cnt_r   <= '0;
            a_r          <= '0;
            b_r          <= '0;
            mat_loaded_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r <= state_s;
            err_r   <= drop_s;

            if (mat_ok_s) begin
                a_r[mat_idx_r] <= in_data;
                if (mat_idx_r == MW'(N*N-1)) begin
                    mat_idx_r    <= '0;
                    mat_loaded_r <= 1'b1;
                end else begin
                    mat_idx_r <= mat_idx_r + MW'(1);
                end
            end

            if (vec_ok_s) begin
                b_r[vec_idx_r] <= in_data;
                if (vec_last_s) begin
                    vec_idx_r  <= '0;
                    wait_cnt_r <= '0;
                end else begin
                    vec_idx_r <= vec_idx_r + VW'(1);
                end
            end

            if (state_r == S_WAIT) begin
                wait_cnt_r <= wait_cnt_r + CW'(1);
            end
        end
    end

    matmul_out_ser #(
        .W (W),
        .N (N)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (cap_s),
        .x_i       (x_i),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (ser_done_s)
    );

    assign in_ready   = (state_r == S_FILL);
    assign a_o        = a_r;
    assign b_o        = b_r;
    assign mat_loaded = mat_loaded_r;
    assign err        = err_r;

endmodule

// File: tb/tb_matmul_stream_if.sv
// Directed bench for matmul_stream_if. The datapath is replaced by a
// stub with a LATENCY-cycle pipeline whose function is selectable:
//   mode 0: permutation-matrix select (exact result for an identity)
//   mode 1: b + 1 per word
//   mode 2: a[r][r] + b[r] per row (integer add)
module tb_matmul_stream_if;
    import vm_pkg::*;

    localparam int W   = 16;
    localparam int N   = 4;
    localparam int LAT = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [W-1:0]          in_data;
    logic                  in_mat;
    logic [N*N-1:0][W-1:0] a_o;
    logic [N-1:0][W-1:0]   b_o;
    logic [N-1:0][W-1:0]   x_i;
    logic                  out_valid;
    logic                  out_ready;
    logic [W-1:0]          out_data;
    logic                  out_last;
    logic                  mat_loaded;
    logic                  err;

    int n_tests = 0;
    int n_fail  = 0;
    int mode    = 0;

    matmul_stream_if #(.W(W), .N(N), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mat     (in_mat),
        .a_o        (a_o),
        .b_o        (b_o),
        .x_i        (x_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .mat_loaded (mat_loaded),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0][W-1:0] stub(input int md,
                                                 input logic [N*N-1:0][W-1:0] a,
                                                 input logic [N-1:0][W-1:0] b);
        logic [N-1:0][W-1:0] res;
        logic found;
        res = '0;
        for (int r = 0; r < N; r++) begin
            case (md)
                0: begin
                    found = 1'b0;
                    for (int c = 0; c < N; c++) begin
                        if (!found && a[r*N+c] == FP16_ONE) begin
                            res[r] = b[c];
                            found  = 1'b1;
                        end
                    end
                end
                1: res[r] = b[r] + 16'd1;
                default: res[r] = a[r*N+r] + b[r];
            endcase
        end
        return res;
    endfunction

    // Stub datapath: combinational function then LAT-1 register stages,
    // so x_i only reflects the final operands LAT edges after they settle.
    logic [N-1:0][W-1:0] f_s, p1, p2, p3;
    always_comb f_s = stub(mode, a_o, b_o);
    always @(posedge clk) begin
        p1 <= f_s;
        p2 <= p1;
        p3 <= p2;
    end
    assign x_i = p3;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic m, input logic [W-1:0] d);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_mat   = m;
        in_data  = d;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready %0b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // kind 0: identity, kind 1: rows filled with the row constants
    task automatic load_matrix(input int kind, input bit chk_loaded);
        fp16_t rowv[4];
        fp16_t w;
        rowv = '{16'h34CD, 16'h2920, 16'h35C3, 16'h39C3};
        for (int i = 0; i < N*N; i++) begin
            if (kind == 0) w = (i % (N+1) == 0) ? FP16_ONE : FP16_ZERO;
            else           w = rowv[i/N];
            send_word(1'b1, w);
            if (chk_loaded && i == N*N-2) check("mat_loaded_15", mat_loaded, 1'b0);
            if (chk_loaded && i == N*N-1) check("mat_loaded_16", mat_loaded, 1'b1);
        end
    endtask

    task automatic wait_latency(input string tag);
        int cnt;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check({tag, "_latency"}, cnt, LAT);
    endtask

    task automatic recv_group(input fp16_t exp[4], input string tag, input int stall_at);
        int t;
        bit stable;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            t = 0;
            while (!out_valid && t < 40) begin
                @(negedge clk);
                t++;
            end
            check({tag, "_valid"}, out_valid, 1'b1);
            check({tag, "_data"}, out_data, exp[k]);
            check({tag, "_last"}, out_last, (k == N-1));
            if (k == stall_at) begin
                out_ready = 1'b0;
                stable = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (out_data !== exp[k] || !out_valid || in_ready) stable = 1'b0;
                end
                check({tag, "_stall_stable"}, stable, 1'b1);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
        check({tag, "_valid_drop"}, out_valid, 1'b0);
        check({tag, "_in_ready_back"}, in_ready, 1'b1);
    endtask

    typedef struct {
        int    md;
        fp16_t vtx[4];
        fp16_t exp[4];
    } vec_t;

    vec_t tbl[3];
    vec_t b2b[3];
    logic [N*N-1:0][W-1:0] a_snap;
    fp16_t ev[4];
    int drv_to = 0;
    int busy_bad = 0;

    initial begin
        tbl[0] = '{md: 0, vtx: '{16'h3E9A, 16'h3AE1, 16'h40CD, 16'h3C00},
                          exp: '{16'h3E9A, 16'h3AE1, 16'h40CD, 16'h3C00}};
        tbl[1] = '{md: 1, vtx: '{16'h3E9A, 16'h3AE1, 16'h40CD, 16'h3C00},
                          exp: '{16'h3E9B, 16'h3AE2, 16'h40CE, 16'h3C01}};
        tbl[2] = '{md: 1, vtx: '{16'h0000, 16'hFFFF, 16'h7BFF, 16'h8000},
                          exp: '{16'h0001, 16'h0000, 16'h7C00, 16'h8001}};
        b2b[0] = '{md: 2, vtx: '{16'h3C00, 16'h4000, 16'h4200, 16'h4400},
                          exp: '{16'h70CD, 16'h6920, 16'h77C3, 16'h7DC3}};
        b2b[1] = '{md: 2, vtx: '{16'h0001, 16'h0002, 16'h0003, 16'h0004},
                          exp: '{16'h34CE, 16'h2922, 16'h35C6, 16'h39C7}};
        b2b[2] = '{md: 2, vtx: '{16'h1000, 16'hC000, 16'h8000, 16'h0100},
                          exp: '{16'h44CD, 16'hE920, 16'hB5C3, 16'h3AC3}};

        rst = 1'b1; in_valid = 1'b0; in_mat = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_a_zero", (a_o == '0), 1'b1);
        check("rst_b_zero", (b_o == '0), 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_out_last", out_last, 1'b0);
        check("rst_mat_loaded", mat_loaded, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);

        // Vertex word before any matrix: dropped with a one-cycle err
        send_word(1'b0, 16'h1234);
        check("vtx_early_err", err, 1'b1);
        @(posedge clk);
        #1;
        check("vtx_early_err_clr", err, 1'b0);
        check("vtx_early_b_zero", (b_o == '0), 1'b1);

        load_matrix(0, 1'b1);

        for (int i = 0; i < 3; i++) begin
            mode = tbl[i].md;
            for (int k = 0; k < N; k++) send_word(1'b0, tbl[i].vtx[k]);
            check("b_o_last", b_o[N-1], tbl[i].vtx[N-1]);
            wait_latency($sformatf("tbl%0d", i));
            recv_group(tbl[i].exp, $sformatf("tbl%0d", i), -1);
        end

        // Matrix word after two vertex words is dropped, then the vertex
        // completes; drain includes a 10-cycle out_ready stall.
        mode = 1;
        send_word(1'b0, 16'h0A00);
        send_word(1'b0, 16'h0B00);
        a_snap = a_o;
        send_word(1'b1, 16'hFFFF);
        check("mat_mid_err", err, 1'b1);
        @(posedge clk);
        #1;
        check("mat_mid_err_clr", err, 1'b0);
        check("mat_mid_a_same", (a_o == a_snap), 1'b1);
        send_word(1'b0, 16'h0C00);
        send_word(1'b0, 16'h0D00);
        wait_latency("bp");
        ev = '{16'h0A01, 16'h0B01, 16'h0C01, 16'h0D01};
        recv_group(ev, "bp", 2);

        // Reset while waiting on the datapath
        mode = 0;
        for (int k = 0; k < N; k++) send_word(1'b0, 16'(k + 1));
        pulse_rst();
        check("rstw_out_valid", out_valid, 1'b0);
        check("rstw_in_ready", in_ready, 1'b1);
        check("rstw_a_zero", (a_o == '0), 1'b1);
        check("rstw_mat_loaded", mat_loaded, 1'b0);
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("rstw_no_capture", out_valid, 1'b0);

        // Reset while draining
        load_matrix(0, 1'b0);
        for (int k = 0; k < N; k++) send_word(1'b0, 16'(k + 5));
        wait_latency("rstd");
        pulse_rst();
        check("rstd_out_valid", out_valid, 1'b0);
        check("rstd_out_data", out_data, 16'h0000);
        check("rstd_in_ready", in_ready, 1'b1);
        check("rstd_a_zero", (a_o == '0), 1'b1);
        check("rstd_mat_loaded", mat_loaded, 1'b0);

        // Back-to-back vertices with in_valid held high
        load_matrix(1, 1'b0);
        mode = 2;
        fork
            begin : drv
                int t;
                for (int g = 0; g < 3; g++) begin
                    for (int k = 0; k < N; k++) begin
                        @(negedge clk);
                        in_valid = 1'b1;
                        in_mat   = 1'b0;
                        in_data  = b2b[g].vtx[k];
                        t = 0;
                        while (!in_ready && t < 60) begin
                            @(negedge clk);
                            t++;
                        end
                        if (!in_ready) drv_to++;
                        @(posedge clk);
                    end
                end
                #1;
                in_valid = 1'b0;
            end
            begin : col
                int t;
                out_ready = 1'b1;
                for (int g = 0; g < 3; g++) begin
                    for (int k = 0; k < N; k++) begin
                        @(negedge clk);
                        t = 0;
                        while (!out_valid && t < 60) begin
                            @(negedge clk);
                            t++;
                        end
                        check("b2b_valid", out_valid, 1'b1);
                        check($sformatf("b2b%0d_data%0d", g, k), out_data, b2b[g].exp[k]);
                        check("b2b_last", out_last, (k == N-1));
                        if (in_ready) busy_bad++;
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
            end
        join
        check("b2b_in_ready_low", busy_bad, 0);
        check("b2b_drv_timeout", drv_to, 0);
        check("b2b_idle_valid", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so a stuck handshake still ends the run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/matmul_stream_if.md
Name: matmul_stream_if

Overview:
- Streaming front/back end for the existing `matmul` datapath (4x4 FP16 matrix times 4-element FP16 vector).
- Accepts a serial stream of FP16 words on a valid/ready input, assembles the matrix (`a`) and vertex (`b`), and holds them stable for the matmul latency.
- Then captures the result (`x`) and re-serialises it as 4 FP16 words on a valid/ready output.
- Initiator side for matmul's parallel `a`/`b` inputs; consumer side for its `x` output.

Parameters:
- W, 16, word width (IEEE-754 half precision).
- N, 4, vector length; matrix is N*N words.
- LATENCY, 4, cycles from final `b_o` update to `x_i` sampling; must be >= 1.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input word valid
- in_ready  output  1  block accepts a word this cycle
- in_data  input  W  FP16 word
- in_mat  input  1  1 = matrix word, 0 = vertex word
- a_o  output  [N*N-1:0][W-1:0]  matrix to matmul `a`, row-major, index row*N+col
- b_o  output  [N-1:0][W-1:0]  vertex to matmul `b`
- x_i  input  [N-1:0][W-1:0]  result from matmul `x`
- out_valid  output  1  result word valid
- out_ready  input  1  downstream accepts a result word
- out_data  output  W  result word
- out_last  output  1  high with the N-th result word
- mat_loaded  output  1  a full matrix has been loaded since reset
- err  output  1  one-cycle pulse when an input word is dropped

Behaviour:
- Reset (synchronous, `rst`=1 at the edge), overriding everything including mid-transfer:
  - outputs: `a_o`=0, `b_o`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `mat_loaded`=0, `err`=0;
  - internal: state=S_FILL, `mat_idx`=0, `vec_idx`=0, `out_idx`=0, `wait_cnt`=0.
- States: S_FILL, S_WAIT, S_DRAIN. Internal `x_cap` register holds the captured result.
- `in_ready` = (state==S_FILL), combinational. A transfer is `in_valid` && `in_ready`.
- S_FILL, matrix word (`in_mat`=1):
  - Accepted only if `vec_idx`==0: `a_o[mat_idx]`<=`in_data`; `mat_idx` increments, wrapping 15->0.
  - On the wrap, `mat_loaded`<=1 (sticky). A partial reload overwrites only the written entries.
  - If `vec_idx`!=0: word dropped, `err` pulses for one cycle, no state change.
- S_FILL, vertex word (`in_mat`=0):
  - Accepted only if `mat_loaded`=1: `b_o[vec_idx]`<=`in_data`; `vec_idx` increments.
  - When `vec_idx`==N-1: `vec_idx`<=0, `wait_cnt`<=0, next state S_WAIT.
  - If `mat_loaded`=0: word dropped, `err` pulse.
  - A vertex word while a matrix reload is partial (`mat_idx`!=0) is accepted; matmul sees the mixed matrix. Software avoids this case.
- S_WAIT:
  - `wait_cnt` increments each cycle.
  - Let E0 be the edge that writes the last `b_o` word. At edge E0+LATENCY: `x_cap`<=`x_i`, `out_idx`<=0, `out_valid`<=1, state S_DRAIN.
  - `a_o` and `b_o` are never written outside S_FILL, so they are stable during S_WAIT.
- S_DRAIN:
  - `out_data` = `x_cap[out_idx]`; `out_last` = (`out_idx`==N-1); `out_valid` held until the handshake.
  - Output transfer (`out_valid` && `out_ready`) increments `out_idx`.
  - On the transfer with `out_last`=1: `out_valid`<=0, state S_FILL. The next input is accepted on the following cycle, with no same-cycle bypass.
  - `out_ready` low stalls indefinitely with `out_data` stable.
- Arithmetic: none; words pass bit-exact. Counters are `$clog2(N*N)`, `$clog2(N)` and `$clog2(LATENCY+1)` bits wide.
- Throughput for N=4: 4 in + LATENCY + 4 out cycles per vertex, minimum.

Decomposition:
- Shared package `vm_pkg`: `fp16_t` (`logic [15:0]`), `VM_N`=4, state enum `vm_state_t` {S_FILL, S_WAIT, S_DRAIN}, FP16 constants `FP16_ONE`=16'h3C00 and `FP16_ZERO`=16'h0000.
- One natural sub-module, `matmul_out_ser`: captures `x_i` on load and serialises it with valid/ready/last. The FSM and input assembly remain in the top.

Test Plan:
- Identity: load 16 words (`FP16_ONE` on the diagonal, 0 elsewhere), then vertex {16'h3E9A, 16'h3AE1, 16'h40CD, 16'h3C00}, with real matmul and LATENCY matched to it -> outputs 3E9A, 3AE1, 40CD, 3C00 in order, `out_last` on the 4th, `mat_loaded`=1 after the 16th word.
- Latency: stub matmul returns `b`+1 per word, LATENCY=4 -> `out_valid` rises exactly 4 edges after the last `b_o` write, with values 3E9B, 3AE2, 40CE, 3C01.
- Errors: vertex word before any matrix load -> `err` 1-cycle pulse, `b_o` stays 0. Matrix word after 2 vertex words -> `err` pulse, `a_o` unchanged.
- Backpressure: `out_ready` low for 10 cycles mid-drain -> `out_data` stable, `in_ready`=0, no word lost or duplicated.
- Reset mid-operation: assert `rst` for one cycle during S_WAIT, then during S_DRAIN -> next cycle `out_valid`=0, `in_ready`=1, `a_o`=0, `mat_loaded`=0.
- Back-to-back: matrix from 0x34CD, 0x2920, 0x35C3, 0x39C3 rows, then 3 vertices with `in_valid` held high -> 3 result groups, `in_ready` low throughout S_WAIT/S_DRAIN, results match the reference model.
